// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module : imem_loader_pkg
// Brief  : Shared constants and loader state encoding for the instruction
//          memory and its program loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    localparam int IMEM_DEPTH = 32;
    localparam int IMEM_AW    = 5;
    localparam int INSTR_W    = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_CHK   = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/imem_program_loader.sv
// ============================================================================
// Module : imem_program_loader
// Brief  : Fills the instruction memory from a framed byte stream and holds
//          the CPU while loading. IMEM_LOADER_CHECKSUM_EN adds a trailing
//          XOR checksum byte.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_program_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW,
    parameter int DW    = INSTR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [DW-1:0] imem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [AW:0]   words_loaded
);

    loader_state_t state_q;
    logic [AW:0]   n_q;
    logic [7:0]    hi_q;
    logic [AW-1:0] addr_q;
    logic [AW:0]   words_q;
    logic          in_ready_q;
    logic          we_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] wdata_q;
    logic          hold_q;
    logic          done_q;
    logic          error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    logic          accept;
    logic [AW:0]   words_inc;
    logic          hdr_bad;

    assign accept    = in_valid && in_ready_q;
    assign words_inc = words_q + (AW+1)'(1);
    assign hdr_bad   = (in_data == 8'd0) || (in_data > 8'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            hi_q       <= '0;
            addr_q     <= '0;
            words_q    <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q    <= S_HDR;
                        in_ready_q <= 1'b1;
                        hold_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        words_q    <= '0;
                        addr_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        if (hdr_bad) begin
                            state_q    <= S_ERROR;
                            in_ready_q <= 1'b0;
                            hold_q     <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            n_q     <= in_data[AW:0];
                            state_q <= S_HI;
                        end
                    end
                end
                S_HI: begin
                    if (accept) begin
                        hi_q    <= in_data;
                        state_q <= S_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q  <= csum_q ^ in_data;
`endif
                    end
                end
                S_LO: begin
                    if (accept) begin
                        // Strobe, address and count all become visible together.
                        we_q    <= 1'b1;
                        wdata_q <= {hi_q, in_data};
                        waddr_q <= addr_q;
                        addr_q  <= addr_q + AW'(1);
                        words_q <= words_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q  <= csum_q ^ in_data;
                        state_q <= (words_inc == n_q) ? S_CHK : S_HI;
`else
                        if (words_inc == n_q) begin
                            state_q    <= S_DONE;
                            in_ready_q <= 1'b0;
                            hold_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            state_q <= S_HI;
                        end
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        hold_q     <= 1'b0;
                        if (in_data == csum_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    hold_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = waddr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_program_loader.sv
// ============================================================================
// Module : tb_imem_program_loader
// Brief  : Scoreboard bench for imem_program_loader; expected writes are
//          queued by the stimulus and popped by an independent monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_program_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [5:0]  words_loaded;

    int n_checks = 0;
    int n_pass   = 0;

    logic [20:0] exp_q[$];
    logic        prev_we = 1'b0;
    logic        rand_gaps = 1'b0;

    imem_program_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            chk("we_not_back_to_back", {31'd0, prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {11'd0, imem_addr, imem_wdata}, 32'hFFFF_FFFF);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                chk("write_addr_data", {11'd0, imem_addr, imem_wdata}, {11'd0, e});
            end
        end
        prev_we = imem_we;
    end

    task automatic gap();
        int g;
        g = rand_gaps ? int'($urandom_range(0, 3)) : 0;
        repeat (g) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        gap();
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [4:0] a, input logic [7:0] hi, input logic [7:0] lo);
        exp_q.push_back({a, hi, lo});
        send_byte(hi);
        send_byte(lo);
    endtask

    task automatic settle_and_check(input string tag, input logic exp_done, input logic exp_err,
                                    input logic [5:0] exp_words);
        repeat (3) @(negedge clk);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        chk({tag, "_words"}, {26'd0, words_loaded}, {26'd0, exp_words});
        chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_pending"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic load_full(input string tag);
        pulse_start();
        send_byte(8'h20);
        for (int i = 0; i < 32; i++)
            send_word(5'(i), 8'(i * 3), 8'(8'hA0 + i));
        settle_and_check(tag, 1'b1, 1'b0, 6'd32);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_we", {31'd0, imem_we}, 32'd0);
        chk("reset_hold", {31'd0, cpu_hold}, 32'd0);
        chk("reset_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_words", {26'd0, words_loaded}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two-word program; hold must rise right after start.
        pulse_start();
        chk("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        chk("ready_after_start", {31'd0, in_ready}, 32'd1);
        send_byte(8'h02);
        send_word(5'd0, 8'h04, 8'h58);
        chk("hold_mid_load", {31'd0, cpu_hold}, 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(5'd1, 8'hF4, 8'h7A);
        send_byte(8'h04 ^ 8'h58 ^ 8'hF4 ^ 8'h7A);
`else
        send_word(5'd1, 8'hF4, 8'h7A);
`endif
        settle_and_check("two_words", 1'b1, 1'b0, 6'd2);

        // Start ignored mid-load is exercised by the bad-header cases' neighbours.
        pulse_start();
        send_byte(8'h00);
        settle_and_check("hdr_zero", 1'b0, 1'b1, 6'd0);

        pulse_start();
        send_byte(8'h21);
        settle_and_check("hdr_33", 1'b0, 1'b1, 6'd0);

`ifndef IMEM_LOADER_CHECKSUM_EN
        load_full("full_32");
        rand_gaps = 1'b1;
        load_full("full_32_gaps");
        rand_gaps = 1'b0;
`endif

        // Reset after three words of a ten-word load.
        pulse_start();
        send_byte(8'h0A);
        send_word(5'd0, 8'h11, 8'h22);
        // A start pulse mid-load must not restart the frame.
        pulse_start();
        send_word(5'd1, 8'h33, 8'h44);
        send_word(5'd2, 8'h55, 8'h66);
        repeat (2) @(negedge clk);
        chk("mid_words", {26'd0, words_loaded}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_hold", {31'd0, cpu_hold}, 32'd0);
        chk("rst_mid_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mid_words", {26'd0, words_loaded}, 32'd0);
        chk("rst_mid_pending", exp_q.size(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        pulse_start();
        send_byte(8'h01);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(5'd0, 8'hBE, 8'hEF);
        send_byte(8'hBE ^ 8'hEF);
`else
        send_word(5'd0, 8'hBE, 8'hEF);
`endif
        settle_and_check("after_reset", 1'b1, 1'b0, 6'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start();
        send_byte(8'h01);
        send_word(5'd0, 8'h12, 8'h34);
        send_byte(8'h26);
        settle_and_check("csum_ok", 1'b1, 1'b0, 6'd1);

        pulse_start();
        send_byte(8'h01);
        send_word(5'd0, 8'h12, 8'h34);
        send_byte(8'h00);
        settle_and_check("csum_bad", 1'b0, 1'b1, 6'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
